// File: rtl/even_clk_div.sv
// Divide-by-2/4/8 built on a 3-bit down-counter; each output bit is a register bit.
// Latency: outputs change one clk_in edge after release; no backpressure (free-running clocks).
module even_div_cnt (
  input  logic clk_in,
  input  logic rst_n,
  output logic clk_out2,
  output logic clk_out4,
  output logic clk_out8
);

  logic [2:0] cnt;

  // Counting down from 000 makes every output rise together on the first edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cnt <= 3'b000;
    else        cnt <= cnt - 3'd1;
  end

  assign clk_out2 = cnt[0];
  assign clk_out4 = cnt[1];
  assign clk_out8 = cnt[2];

endmodule

// Divide-by-2/4/8 built as a ripple chain of toggle flops, each clocked by the previous stage.
// Latency: stages ripple within one clk_in edge; no backpressure (free-running clocks).
module even_div_dff (
  input  logic clk_in,
  input  logic rst_n,
  output logic clk_out2,
  output logic clk_out4,
  output logic clk_out8
);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) clk_out2 <= 1'b0;
    else        clk_out2 <= ~clk_out2;
  end

  always_ff @(posedge clk_out2 or negedge rst_n) begin
    if (!rst_n) clk_out4 <= 1'b0;
    else        clk_out4 <= ~clk_out4;
  end

  always_ff @(posedge clk_out4 or negedge rst_n) begin
    if (!rst_n) clk_out8 <= 1'b0;
    else        clk_out8 <= ~clk_out8;
  end

endmodule

// Wrapper exposing both divider implementations side by side from one source clock.
// Latency: one clk_in edge; no backpressure. Outputs are generated clocks, not data.
module even_clk_div (
  input  logic clk_in,
  input  logic rst_n,
  output logic clk_out2,
  output logic clk_out4,
  output logic clk_out8,
  output logic dff_clk_out2,
  output logic dff_clk_out4,
  output logic dff_clk_out8
);

  even_div_cnt u_cnt (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .clk_out2 (clk_out2),
    .clk_out4 (clk_out4),
    .clk_out8 (clk_out8)
  );

  even_div_dff u_dff (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .clk_out2 (dff_clk_out2),
    .clk_out4 (dff_clk_out4),
    .clk_out8 (dff_clk_out8)
  );

endmodule

// File: tb/tb_even_clk_div.sv
// Bench for even_clk_div: both implementations against an edge-count model of the divided clocks.
module tb_even_clk_div;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic c2, c4, c8, d2, d4, d8;
  logic [2:0] cs, ds, prev;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int last_rise [3];
  int hi_cnt    [3];

  assign cs = {c8, c4, c2};
  assign ds = {d8, d4, d2};

  even_clk_div dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .clk_out2     (c2),
    .clk_out4     (c4),
    .clk_out8     (c8),
    .dff_clk_out2 (d2),
    .dff_clk_out4 (d4),
    .dff_clk_out8 (d8)
  );

  always #5 clk_in = ~clk_in;

  // After n edges out of reset, a divider that counts down from zero reads (-n) mod 8.
  function automatic logic [2:0] model(input int edges);
    int v;
    v = (8 - (edges % 8)) % 8;
    return v[2:0];
  endfunction

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic restart();
    n    = 0;
    prev = 3'b000;
    for (int i = 0; i < 3; i++) begin
      last_rise[i] = -1;
      hi_cnt[i]    = 0;
    end
  endtask

  // One clk_in edge: state of both implementations, rising-edge pattern, period and duty.
  task automatic step();
    logic [2:0] rose, exp_rose;
    int per;
    @(posedge clk_in);
    n++;
    @(negedge clk_in);
    chk3("cnt_state", cs, model(n));
    chk3("dff_state", ds, model(n));
    rose     = cs & ~prev;
    exp_rose = {(n % 8) == 1, (n % 4) == 1, (n % 2) == 1};
    chk3("rise_pattern", rose, exp_rose);
    for (int i = 0; i < 3; i++) begin
      per = 2 << i;
      if (rose[i]) begin
        if (last_rise[i] >= 0) begin
          chk_int($sformatf("period_div%0d", per), n - last_rise[i], per);
          chk_int($sformatf("high_div%0d", per), hi_cnt[i], per / 2);
        end
        last_rise[i] = n;
        hi_cnt[i]    = 0;
      end
      if (cs[i]) hi_cnt[i]++;
    end
    prev = cs;
  endtask

  // Reset away from any clock edge, hold it over a few edges, release on a falling edge.
  task automatic mid_reset(input int offset, input int hold, input string tag);
    #(offset);
    rst_n = 1'b0;
    #1;
    chk3({tag, "_cnt_immediate"}, cs, 3'b000);
    chk3({tag, "_dff_immediate"}, ds, 3'b000);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_in);
      chk3({tag, "_cnt_hold"}, cs, 3'b000);
      chk3({tag, "_dff_hold"}, ds, 3'b000);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    restart();
    step();
    chk3({tag, "_first_edge"}, cs, 3'b111);
  endtask

  initial begin
    int guard;
    restart();
    #1;
    chk3("reset_cnt_initial", cs, 3'b000);
    chk3("reset_dff_initial", ds, 3'b000);

    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      chk3("reset_cnt_hold", cs, 3'b000);
      chk3("reset_dff_hold", ds, 3'b000);
    end

    rst_n = 1'b1;
    restart();
    step();
    chk3("first_edge_111", cs, 3'b111);
    for (int k = 0; k < 7; k++) step();
    chk3("eighth_edge_000", cs, 3'b000);
    step();
    chk3("ninth_edge_111", cs, 3'b111);

    for (int k = 0; k < 200; k++) step();

    guard = 0;
    while (model(n) != 3'b101 && guard < 8) begin
      step();
      guard++;
    end
    chk3("reached_101", cs, 3'b101);
    mid_reset(2, 2, "reset_at_101");

    for (int r = 0; r < 6; r++) begin
      int run_len;
      run_len = $urandom_range(3, 40);
      for (int k = 0; k < run_len; k++) step();
      mid_reset($urandom_range(1, 4), $urandom_range(0, 3), "rand_reset");
    end

    for (int k = 0; k < 40; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
